// File: rtl/izhikevich_state_update.sv
// Izhikevich neuron state owner: integrates one (dv, dw) pair per timestep,
// applies the spike/reset rule and presents v, w and the spike flag downstream.
module izhikevich_state_update #(
    parameter int              N     = 32,
    parameter int              Q     = 16,
    parameter logic [N-1:0]    V_RST = 32'h80410000,
    parameter logic [N-1:0]    W_RST = 32'h800D0000,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     dv,
    input  logic [N-1:0]     dw,
    input  logic [N-1:0]     c,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     v_th,
    input  logic             load,
    input  logic [N-1:0]     v_init,
    input  logic [N-1:0]     w_init,
    output logic [N-1:0]     v,
    output logic [N-1:0]     w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             spike,
    output logic [CNT_W-1:0] spike_count
);

    // The fraction point only matters to whoever interprets the words; it must
    // still fit inside the magnitude field.
    if (Q > N - 1) begin : g_bad_q
        $error("Q exceeds the magnitude width");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTEG,
        S_CHECK,
        S_FIRE,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]     v_q, w_q;
    logic [N-1:0]     dv_q, dw_q, c_q, d_q, vth_q;
    logic             spike_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fire;

    function automatic logic [N-1:0] sm_norm(input logic [N-1:0] a);
        return (a[N-2:0] == '0) ? '0 : a;
    endfunction

    function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] ma, mb, mag;
        logic         sa, sb, s;
        logic [N-1:0] sum;
        ma  = a[N-2:0];
        mb  = b[N-2:0];
        sa  = a[N-1] & (|ma);
        sb  = b[N-1] & (|mb);
        sum = '0;
        if (sa == sb) begin
            sum = {1'b0, ma} + {1'b0, mb};
            mag = sum[N-1] ? '1 : sum[N-2:0];
            s   = sa;
        end else if (ma >= mb) begin
            mag = ma - mb;
            s   = sa;
        end else begin
            mag = mb - ma;
            s   = sb;
        end
        if (mag == '0) s = 1'b0;
        return {s, mag};
    endfunction

    // Signed a >= b; -0 collapses onto +0 through the two's-complement view.
    function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [N:0] ta, tb;
        ta = a[N-1] ? -$signed({2'b00, a[N-2:0]}) : $signed({2'b00, a[N-2:0]});
        tb = b[N-1] ? -$signed({2'b00, b[N-2:0]}) : $signed({2'b00, b[N-2:0]});
        return ta >= tb;
    endfunction

    assign fire = sm_ge(v_q, vth_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!load && in_valid) state_d = S_INTEG;
            S_INTEG: state_d = S_CHECK;
            S_CHECK: state_d = fire ? S_FIRE : S_OUT;
            S_FIRE:  state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= V_RST;
            w_q     <= W_RST;
            spike_q <= 1'b0;
            cnt_q   <= '0;
            dv_q    <= '0;
            dw_q    <= '0;
            c_q     <= '0;
            d_q     <= '0;
            vth_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        v_q <= sm_norm(v_init);
                        w_q <= sm_norm(w_init);
                    end else if (in_valid) begin
                        dv_q  <= dv;
                        dw_q  <= dw;
                        c_q   <= c;
                        d_q   <= d;
                        vth_q <= v_th;
                    end
                end
                S_INTEG: begin
                    v_q <= sm_add(v_q, dv_q);
                    w_q <= sm_add(w_q, dw_q);
                end
                S_CHECK: spike_q <= fire;
                S_FIRE: begin
                    v_q   <= sm_norm(c_q);
                    w_q   <= sm_add(w_q, d_q);
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign v           = v_q;
    assign w           = w_q;
    assign spike       = spike_q;
    assign spike_count = cnt_q;

endmodule
